rename_free_list: RTL and testbench

- Pool of free physical register tags feeding the 3-wide rename stage; grants up to 3 destination tags per cycle to renamed uops.
- Accepts up to 3 released tags per cycle from the commit stage (previous mappings of retired destinations).
- Circular FIFO of tags. Reset contents match the remap table reset: architectural reg i maps to tag i, so tags NUM_AREGS..NUM_PREGS-1 start free.

---
 rtl/rename_free_list.sv | 130 +++++++++++++
 tb/tb_rename_free_list.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rename_free_list.sv
`default_nettype none
// ============================================================================
// Module      : rename_free_list
// Description : Circular FIFO of free physical register tags. Grants up to
//               WIDTH tags per cycle to the rename stage (all-or-nothing) and
//               accepts up to WIDTH released tags per cycle from commit.
//               Pushes that would exceed the capacity are dropped and raise a
//               sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rename_free_list #(
  parameter  int NUM_PREGS = 64,
  parameter  int NUM_AREGS = 15,
  parameter  int TAG_W     = 6,
  parameter  int WIDTH     = 3,
  localparam int c_CNT_W   = $clog2(NUM_PREGS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            alloc_req_i,
  output logic                        alloc_ready_o,
  output logic [WIDTH-1:0][TAG_W-1:0] alloc_tags_o,
  input  logic [WIDTH-1:0]            free_valid_i,
  input  logic [WIDTH-1:0][TAG_W-1:0] free_tags_i,
  output logic [c_CNT_W-1:0]          count_o,
  output logic                        empty_o,
  output logic                        err_o
);

  // Tags not held by an architectural register at reset; never exceeded.
  localparam int c_MAXF = NUM_PREGS - NUM_AREGS;
  localparam int c_PC_W = $clog2(WIDTH + 1);

  logic [TAG_W-1:0]   mem_q [NUM_PREGS];
  logic [TAG_W-1:0]   head_q, head_d;
  logic [TAG_W-1:0]   tail_q, tail_d;
  logic [c_CNT_W-1:0] count_q, count_d;
  logic               err_q;

  logic [c_PC_W-1:0]  w_req_cnt;
  logic [c_PC_W-1:0]  w_free_cnt;
  logic [c_PC_W-1:0]  w_pop_cnt;
  logic [c_CNT_W:0]   w_cnt_sum;
  logic               w_overflow;
  logic [TAG_W-1:0]   w_rd_ptr;
  logic [TAG_W-1:0]   w_wr_ptr;
  logic [TAG_W-1:0]   w_wr_addr [WIDTH];
  logic [WIDTH-1:0]   w_wr_en;

  // Population counts of the request and release vectors.
  always_comb begin
    w_req_cnt  = '0;
    w_free_cnt = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_req_cnt  = w_req_cnt  + c_PC_W'(alloc_req_i[k]);
      w_free_cnt = w_free_cnt + c_PC_W'(free_valid_i[k]);
    end
  end

  // Readiness looks only at the registered count: freed tags are not bypassed.
  assign alloc_ready_o = !rst && (c_CNT_W'(w_req_cnt) <= count_q);

  // Requested slots take consecutive entries from head in slot order.
  always_comb begin
    w_rd_ptr = head_q;
    for (int k = 0; k < WIDTH; k++) begin
      alloc_tags_o[k] = '0;
      if (alloc_req_i[k]) begin
        alloc_tags_o[k] = mem_q[w_rd_ptr];
        w_rd_ptr        = w_rd_ptr + TAG_W'(1);
      end
    end
  end

  // Next-state pointers/count; an overflowing cycle drops every push but still pops.
  always_comb begin
    w_pop_cnt  = (alloc_ready_o && (|alloc_req_i)) ? w_req_cnt : '0;
    w_cnt_sum  = {1'b0, count_q} - (c_CNT_W+1)'(w_pop_cnt) + (c_CNT_W+1)'(w_free_cnt);
    w_overflow = (w_cnt_sum > (c_CNT_W+1)'(c_MAXF));
    head_d     = head_q + TAG_W'(w_pop_cnt);
    if (w_overflow) begin
      tail_d  = tail_q;
      count_d = count_q - c_CNT_W'(w_pop_cnt);
    end else begin
      tail_d  = tail_q + TAG_W'(w_free_cnt);
      count_d = w_cnt_sum[c_CNT_W-1:0];
    end
  end

  // Valid releases are compressed onto consecutive addresses starting at tail.
  always_comb begin
    w_wr_ptr = tail_q;
    for (int k = 0; k < WIDTH; k++) begin
      w_wr_addr[k] = w_wr_ptr;
      w_wr_en[k]   = free_valid_i[k] && !w_overflow;
      if (free_valid_i[k]) begin
        w_wr_ptr = w_wr_ptr + TAG_W'(1);
      end
    end
  end

  // State update; reset reloads the tags not owned by architectural registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        mem_q[i] <= (i < c_MAXF) ? TAG_W'(NUM_AREGS + i) : '0;
      end
      head_q  <= '0;
      tail_q  <= TAG_W'(c_MAXF);
      count_q <= c_CNT_W'(c_MAXF);
      err_q   <= 1'b0;
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        if (w_wr_en[k]) begin
          mem_q[w_wr_addr[k]] <= free_tags_i[k];
        end
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_q | w_overflow;
    end
  end

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rename_free_list.sv
`default_nettype none
// ============================================================================
// Module      : tb_rename_free_list
// Description : Self-checking bench for rename_free_list. A queue-based model
//               of the free pool predicts readiness, granted tags, count,
//               empty and the sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rename_free_list;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       alloc_req_i = '0;
  logic             alloc_ready_o;
  logic [2:0][5:0]  alloc_tags_o;
  logic [2:0]       free_valid_i = '0;
  logic [2:0][5:0]  free_tags_i = '0;
  logic [6:0]       count_o;
  logic             empty_o;
  logic             err_o;

  int total = 0;
  int bad   = 0;

  // Reference model: the free pool as an ordered queue, plus tags in use.
  int m_q[$];
  int out_q[$];
  bit m_err;

  logic            obs_ready;
  logic [2:0][5:0] obs_tags;

  logic [2:0]      r_req, r_fv;
  logic [2:0][5:0] r_ft;
  int              idx;

  rename_free_list dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req_i  (alloc_req_i),
    .alloc_ready_o(alloc_ready_o),
    .alloc_tags_o (alloc_tags_o),
    .free_valid_i (free_valid_i),
    .free_tags_i  (free_tags_i),
    .count_o      (count_o),
    .empty_o      (empty_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("count", int'(count_o), m_q.size());
    check("empty", int'(empty_o), int'(m_q.size() == 0));
    check("err", int'(err_o), int'(m_err));
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    alloc_req_i  = 3'b111;
    free_valid_i = 3'b111;
    free_tags_i  = {6'd9, 6'd8, 6'd7};
    #1;
    check("rst_ready", int'(alloc_ready_o), 0);
    @(posedge clk); #1;
    rst          = 1'b0;
    alloc_req_i  = '0;
    free_valid_i = '0;
    m_q.delete();
    out_q.delete();
    for (int i = 15; i < 64; i++) m_q.push_back(i);
    for (int i = 0; i < 15; i++) out_q.push_back(i);
    m_err = 1'b0;
    #1;
    check_state();
  endtask

  // One clock: drive, check grant outputs, update model, check registered state.
  task automatic step(input logic [2:0] req, input logic [2:0] fv, input logic [2:0][5:0] ft);
    int p, f, n;
    bit rdy;
    alloc_req_i  = req;
    free_valid_i = fv;
    free_tags_i  = ft;
    #1;
    obs_ready = alloc_ready_o;
    obs_tags  = alloc_tags_o;
    p   = $countones(req);
    f   = $countones(fv);
    rdy = (m_q.size() >= p);
    check("ready", int'(alloc_ready_o), int'(rdy));
    if (rdy) begin
      n = 0;
      for (int k = 0; k < 3; k++) begin
        if (req[k]) begin
          check("grant", int'(alloc_tags_o[k]), m_q[n]);
          n++;
        end else begin
          check("idle_slot", int'(alloc_tags_o[k]), 0);
        end
      end
      for (int k = 0; k < p; k++) out_q.push_back(m_q.pop_front());
    end
    if (m_q.size() + f > 49) begin
      m_err = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) if (fv[k]) m_q.push_back(int'(ft[k]));
    end
    @(posedge clk); #1;
    check_state();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: full-width grant from reset, then a single grant continues the order
    do_reset();
    step(3'b111, 3'b000, '0);
    check("t1_ready", int'(obs_ready), 1);
    check("t1_s0", int'(obs_tags[0]), 15);
    check("t1_s1", int'(obs_tags[1]), 16);
    check("t1_s2", int'(obs_tags[2]), 17);
    check("t1_count", int'(count_o), 46);
    step(3'b001, 3'b000, '0);
    check("t1_next", int'(obs_tags[0]), 18);

    // 2: sparse request compresses onto consecutive entries
    do_reset();
    step(3'b101, 3'b000, '0);
    check("t2_s0", int'(obs_tags[0]), 15);
    check("t2_s1", int'(obs_tags[1]), 0);
    check("t2_s2", int'(obs_tags[2]), 16);
    check("t2_count", int'(count_o), 47);

    // 3: drain to one, hold an oversized request, then take the last tag
    do_reset();
    for (int i = 0; i < 16; i++) step(3'b111, 3'b000, '0);
    check("t3_count1", int'(count_o), 1);
    for (int i = 0; i < 3; i++) begin
      step(3'b011, 3'b000, '0);
      check("t3_hold_ready", int'(obs_ready), 0);
      check("t3_hold_count", int'(count_o), 1);
    end
    step(3'b001, 3'b000, '0);
    check("t3_last", int'(obs_tags[0]), 63);
    check("t3_empty", int'(empty_o), 1);

    // 4: frees are not bypassed to a same-cycle request
    do_reset();
    for (int i = 0; i < 15; i++) step(3'b111, 3'b000, '0);
    step(3'b011, 3'b000, '0);
    check("t4_count2", int'(count_o), 2);
    step(3'b111, 3'b111, {6'd7, 6'd6, 6'd5});
    check("t4_noready", int'(obs_ready), 0);
    check("t4_count5", int'(count_o), 5);
    step(3'b111, 3'b000, '0);
    check("t4_s0", int'(obs_tags[0]), 62);
    check("t4_s1", int'(obs_tags[1]), 63);
    check("t4_s2", int'(obs_tags[2]), 5);

    // 5: steady 3-in/3-out traffic across pointer wrap
    do_reset();
    for (int c = 0; c < 40; c++) begin
      for (int k = 0; k < 3; k++) r_ft[k] = 6'(out_q.pop_front());
      step(3'b111, 3'b111, r_ft);
      check("t5_count", int'(count_o), 49);
      check("t5_err", int'(err_o), 0);
    end

    // 6: overflow drops the push and sets the sticky error
    do_reset();
    step(3'b000, 3'b001, {6'd0, 6'd0, 6'd3});
    check("t6_err", int'(err_o), 1);
    check("t6_count", int'(count_o), 49);
    step(3'b001, 3'b000, '0);
    check("t6_err_held", int'(err_o), 1);
    do_reset();
    check("t6_err_clr", int'(err_o), 0);
    check("t6_count_rst", int'(count_o), 49);

    // Randomized mix of requests and releases, with periodic reset
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      r_req = 3'($urandom);
      r_fv  = '0;
      r_ft  = '0;
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 1) == 1 && out_q.size() > 0) begin
          r_fv[k] = 1'b1;
          if ($urandom_range(0, 7) == 0) begin
            r_ft[k] = 6'($urandom);
          end else begin
            idx = $urandom_range(0, out_q.size() - 1);
            r_ft[k] = 6'(out_q[idx]);
            out_q.delete(idx);
          end
        end
      end
      step(r_req, r_fv, r_ft);
      if (c % 400 == 399) do_reset();
    end

    alloc_req_i  = '0;
    free_valid_i = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
